// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage that turns byte-addressed requests into word-memory commands.
// Define MAU_BYTE_ACCESS_EN to build byte loads and read-modify-write byte stores.
module mem_access_unit #(
  parameter int DEPTH = 12,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_load_i,
  input  logic             req_byte_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [TAG_W-1:0] req_rd_i,
  output logic             resp_valid_o,
  output logic             resp_we_o,
  output logic [TAG_W-1:0] resp_rd_o,
  output logic [31:0]      resp_data_o,
  output logic             resp_fault_o,
  output logic             mem_valid_o,
  output logic             mem_r_not_w_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic [31:0]      mem_data_i
);

`ifdef MAU_BYTE_ACCESS_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, WRITE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;
`endif

  state_t            state, state_nxt;
  logic              armed;
  logic              accept, fault, req_read, op_read;
  logic [31:0]       req_index;
  logic              op_load;
  logic [TAG_W-1:0]  op_rd;

  logic              mem_valid_d, mem_r_not_w_d;
  logic [31:0]       mem_addr_d, mem_data_d;
  logic              resp_valid_d, resp_we_d, resp_fault_d;
  logic [TAG_W-1:0]  resp_rd_d;
  logic [31:0]       resp_data_d;

`ifdef MAU_BYTE_ACCESS_EN
  logic              op_byte;
  logic [1:0]        op_lane;
  logic [7:0]        op_wbyte;

  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
    case (lane)
      2'd0:    return {w[31:8], b};
      2'd1:    return {w[31:16], b, w[7:0]};
      2'd2:    return {w[31:24], b, w[15:0]};
      default: return {b, w[23:0]};
    endcase
  endfunction

  assign req_read = req_load_i | req_byte_i;
  assign op_read  = op_load | op_byte;
`else
  assign req_read = req_load_i;
  assign op_read  = op_load;
`endif

  // Handshake: a request transfers on a rising edge where req_valid_i and req_ready_o are
  // both high; ready depends only on state, never on valid. Responses cannot be stalled.
  assign req_ready_o = armed & (state == IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign req_index   = {2'b00, req_addr_i[31:2]};

`ifdef MAU_BYTE_ACCESS_EN
  assign fault = (req_index >= 32'(DEPTH)) | (!req_byte_i && (req_addr_i[1:0] != 2'b00));
`else
  assign fault = (req_index >= 32'(DEPTH)) | (req_addr_i[1:0] != 2'b00) | req_byte_i;
`endif

  // State register; armed holds ready low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !fault) state_nxt = ISSUE;
      ISSUE:   state_nxt = op_read ? CAPTURE : IDLE;
`ifdef MAU_BYTE_ACCESS_EN
      CAPTURE: state_nxt = op_load ? IDLE : WRITE;
      WRITE:   state_nxt = IDLE;
`else
      CAPTURE: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    mem_valid_d   = 1'b0;
    mem_r_not_w_d = mem_r_not_w_o;
    mem_addr_d    = mem_addr_o;
    mem_data_d    = mem_data_o;
    resp_valid_d  = 1'b0;
    resp_we_d     = 1'b0;
    resp_fault_d  = 1'b0;
    resp_rd_d     = '0;
    resp_data_d   = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rd_d    = req_rd_i;
          end else begin
            mem_valid_d   = 1'b1;
            mem_r_not_w_d = req_read;
            mem_addr_d    = req_index;
            if (!req_read) mem_data_d = req_wdata_i;
          end
        end
      end
      ISSUE: begin
        if (!op_read) begin
          resp_valid_d = 1'b1;
          resp_rd_d    = op_rd;
        end
      end
      CAPTURE: begin
        if (op_load) begin
          resp_valid_d = 1'b1;
          resp_we_d    = 1'b1;
          resp_rd_d    = op_rd;
`ifdef MAU_BYTE_ACCESS_EN
          resp_data_d  = op_byte ? {24'd0, lane_sel(mem_data_i, op_lane)} : mem_data_i;
        end else begin
          mem_valid_d   = 1'b1;
          mem_r_not_w_d = 1'b0;
          mem_data_d    = lane_merge(mem_data_i, op_lane, op_wbyte);
`else
          resp_data_d  = mem_data_i;
`endif
        end
      end
`ifdef MAU_BYTE_ACCESS_EN
      WRITE: begin
        resp_valid_d = 1'b1;
        resp_rd_d    = op_rd;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mem_valid_o   <= 1'b0;
      mem_r_not_w_o <= 1'b0;
      mem_addr_o    <= '0;
      mem_data_o    <= '0;
      resp_valid_o  <= 1'b0;
      resp_we_o     <= 1'b0;
      resp_fault_o  <= 1'b0;
      resp_rd_o     <= '0;
      resp_data_o   <= '0;
    end else begin
      mem_valid_o   <= mem_valid_d;
      mem_r_not_w_o <= mem_r_not_w_d;
      mem_addr_o    <= mem_addr_d;
      mem_data_o    <= mem_data_d;
      resp_valid_o  <= resp_valid_d;
      resp_we_o     <= resp_we_d;
      resp_fault_o  <= resp_fault_d;
      resp_rd_o     <= resp_rd_d;
      resp_data_o   <= resp_data_d;
    end
  end

  // Request context kept for the later phases of a multi-cycle access.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_load  <= 1'b0;
      op_rd    <= '0;
`ifdef MAU_BYTE_ACCESS_EN
      op_byte  <= 1'b0;
      op_lane  <= 2'd0;
      op_wbyte <= 8'd0;
`endif
    end else if (accept && !fault) begin
      op_load  <= req_load_i;
      op_rd    <= req_rd_i;
`ifdef MAU_BYTE_ACCESS_EN
      op_byte  <= req_byte_i;
      op_lane  <= req_addr_i[1:0];
      op_wbyte <= req_wdata_i[7:0];
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus reset and back-to-back sequences for mem_access_unit.
// Byte-path rows follow MAU_BYTE_ACCESS_EN so the bench matches either build.
module tb_mem_access_unit;
  localparam int DEPTH = 12;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_load, req_byte;
  logic [31:0]      req_addr, req_wdata;
  logic [TAG_W-1:0] req_rd;
  logic             resp_valid, resp_we, resp_fault;
  logic [TAG_W-1:0] resp_rd;
  logic [31:0]      resp_data;
  logic             mem_valid, mem_rnw;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [31:0]      mem [0:DEPTH-1];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic             load;
    logic             byte_acc;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] rd;
    logic             fault;
    logic             we;
    logic [31:0]      data;
    int               lat;
    int               cmds;
    int               chk_idx;
    logic [31:0]      chk_val;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_load_i(req_load),
    .req_byte_i(req_byte), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .resp_valid_o(resp_valid), .resp_we_o(resp_we), .resp_rd_o(resp_rd),
    .resp_data_o(resp_data), .resp_fault_o(resp_fault),
    .mem_valid_o(mem_valid), .mem_r_not_w_o(mem_rnw), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
  );

  // Word memory: one-cycle registered read, returns 0 in cycles without a read strobe.
  always @(posedge clk) begin
    mem_rdata <= '0;
    if (mem_valid && mem_addr < DEPTH) begin
      if (mem_rnw) mem_rdata <= mem[mem_addr[3:0]];
      else         mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic load, input logic b, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [TAG_W-1:0] rd,
                              input logic fault, input logic we, input logic [31:0] data,
                              input int lat, input int cmds, input int chk_idx,
                              input logic [31:0] chk_val);
    vec_t v;
    v.load = load; v.byte_acc = b; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.fault = fault; v.we = we; v.data = data; v.lat = lat; v.cmds = cmds;
    v.chk_idx = chk_idx; v.chk_val = chk_val;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int w, lat, cmds;
    logic seen, r_we, r_fault;
    logic [TAG_W-1:0] r_rd;
    logic [31:0] r_data;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    req_load = v.load; req_byte = v.byte_acc; req_addr = v.addr;
    req_wdata = v.wdata; req_rd = v.rd; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    seen = 1'b0; lat = 0; cmds = 0;
    r_we = 1'b0; r_fault = 1'b0; r_rd = '0; r_data = '0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_valid) cmds++;
      if (resp_valid) begin
        seen = 1'b1; lat = c;
        r_we = resp_we; r_fault = resp_fault; r_rd = resp_rd; r_data = resp_data;
      end
    end
    req_valid = 1'b0;
    check({tag, " resp_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " fault"}, {31'd0, r_fault}, {31'd0, v.fault});
    check({tag, " we"}, {31'd0, r_we}, {31'd0, v.we});
    check({tag, " rd"}, 32'(r_rd), 32'(v.rd));
    check({tag, " data"}, r_data, v.data);
    check({tag, " mem_cmds"}, 32'(cmds), 32'(v.cmds));
    if (v.chk_idx >= 0) check({tag, " mem_word"}, mem[v.chk_idx], v.chk_val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2, cmds, nresp;
    logic drop;

    for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    mem[0]  <= 32'h00C0FFEE;
    mem[1]  <= 32'h11223344;
    mem[11] <= 32'hCAFEF00D;

    req_valid = 1'b0; req_load = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;

    // Clock/reset: real falling edge on reset, then check reset values before any clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst ready", {31'd0, req_ready}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst release ready", {31'd0, req_ready}, 32'd1);

    vecs.push_back(mk(0, 0, 32'h8,  32'hDEADBEEF, 0, 0, 0, 32'h0,        2, 1,  2, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 32'h8,  32'h0,        3, 0, 1, 32'hDEADBEEF, 3, 1, -1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h6,  32'h0,        5, 1, 0, 32'h0,        1, 0, -1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h30, 32'h0,        6, 1, 0, 32'h0,        1, 0, -1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h2C, 32'h0,        7, 0, 1, 32'hCAFEF00D, 3, 1, -1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h4,  32'h0,        1, 0, 1, 32'h11223344, 3, 1, -1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h2,  32'h99,       9, 1, 0, 32'h0,        1, 0,  0, 32'h00C0FFEE));
    vecs.push_back(mk(0, 0, 32'hFFFFFFFC, 32'h77, 4, 1, 0, 32'h0,        1, 0, -1, 32'h0));
`ifdef MAU_BYTE_ACCESS_EN
    vecs.push_back(mk(0, 1, 32'h5,  32'h123456AB, 2, 0, 0, 32'h0,  4, 2,  1, 32'h1122AB44));
    vecs.push_back(mk(1, 1, 32'h5,  32'h0,        4, 0, 1, 32'hAB, 3, 1, -1, 32'h0));
    vecs.push_back(mk(1, 1, 32'h7,  32'h0,        8, 0, 1, 32'h11, 3, 1, -1, 32'h0));
    vecs.push_back(mk(1, 1, 32'h30, 32'h0,        9, 1, 0, 32'h0,  1, 0, -1, 32'h0));
    vecs.push_back(mk(0, 1, 32'h2F, 32'hA5,      10, 0, 0, 32'h0,  4, 2, 11, 32'hA5FEF00D));
    vecs.push_back(mk(1, 1, 32'h2C, 32'h0,       11, 0, 1, 32'h0D, 3, 1, -1, 32'h0));
`else
    vecs.push_back(mk(0, 1, 32'h5,  32'h123456AB, 2, 1, 0, 32'h0,  1, 0,  1, 32'h11223344));
    vecs.push_back(mk(1, 1, 32'h4,  32'h0,        4, 1, 0, 32'h0,  1, 0, -1, 32'h0));
`endif
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back loads: second request held on the bus while the first is in flight.
    @(negedge clk);
    check("b2b ready0", {31'd0, req_ready}, 32'd1);
    req_load = 1'b1; req_byte = 1'b0; req_addr = 32'h8; req_rd = 4'd1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0; req_rd = 4'd2;
    n1 = 0; n2 = 0; cmds = 0; nresp = 0; drop = 1'b0;
    for (n = 1; n <= 12 && nresp < 2; n++) begin
      if (n > 1) @(negedge clk);
      if (drop) begin
        req_valid = 1'b0;
        drop = 1'b0;
      end
      if (mem_valid) cmds++;
      if (resp_valid) begin
        nresp++;
        if (nresp == 1) begin
          n1 = n;
          drop = 1'b1;
          check("b2b ready_with_resp", {31'd0, req_ready}, 32'd1);
          check("b2b rd1", 32'(resp_rd), 32'd1);
          check("b2b data1", resp_data, 32'hDEADBEEF);
        end else begin
          n2 = n;
          check("b2b rd2", 32'(resp_rd), 32'd2);
          check("b2b data2", resp_data, 32'h00C0FFEE);
        end
      end
    end
    req_valid = 1'b0;
    check("b2b resp1_cycle", 32'(n1), 32'd3);
    check("b2b resp2_cycle", 32'(n2), 32'd6);
    check("b2b mem_cmds", 32'(cmds), 32'd2);

    // Reset asserted while a load sits in CAPTURE.
    @(negedge clk);
    req_load = 1'b1; req_byte = 1'b0; req_addr = 32'h8; req_rd = 4'd3; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst ready", {31'd0, req_ready}, 32'd0);
    check("midrst mem_addr", mem_addr, 32'd0);
    check("midrst mem_rnw", {31'd0, mem_rnw}, 32'd0);
    check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst release ready", {31'd0, req_ready}, 32'd1);
    nresp = 0; cmds = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
      if (mem_valid) cmds++;
    end
    check("midrst no_resp", 32'(nresp), 32'd0);
    check("midrst no_mem", 32'(cmds), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage between execute and the word-addressed data memory. The data memory has one-cycle registered read, word-only writes, a word index address and a `valid` strobe.
- Takes byte-addressed load/store requests from execute and converts them to word indices.
- Performs bounds and alignment checks and sequences memory commands.
- Returns one result pulse per request to writeback.

Parameters:
- DEPTH, 12: number of 32-bit words in data memory; valid word index is 0..DEPTH-1.
- TAG_W, 4: width of destination register tag.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request this cycle
- req_load_i  in  1  1=load, 0=store
- req_byte_i  in  1  1=byte access, 0=word access
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data; byte store uses bits 7:0
- req_rd_i  in  TAG_W  destination tag
- resp_valid_o  out  1  one-cycle completion pulse
- resp_we_o  out  1  writeback enable: 1 for a non-faulting load
- resp_rd_o  out  TAG_W  tag of the completed request
- resp_data_o  out  32  load result; 0 for stores and faults
- resp_fault_o  out  1  request was rejected
- mem_valid_o  out  1  memory command strobe
- mem_r_not_w_o  out  1  1=read, 0=write
- mem_addr_o  out  32  word index
- mem_data_o  out  32  write data
- mem_data_i  in  32  memory read data, valid the cycle after a read strobe

Behaviour:
- Reset: all outputs 0, including req_ready_o. Reset is asynchronous and asserts immediately.
  - Reset mid-operation drops the in-flight request: no response and no further memory command.
  - req_ready_o rises in the first cycle after deassertion.
- All outputs are registered except req_ready_o, which is 1 exactly in state IDLE.
- A request is accepted at a clock edge where req_valid_i & req_ready_o. The unit latches load, byte, addr[1:0], word index = addr>>2, wdata and rd.
- Fault at accept when either condition holds:
  - word index >= DEPTH;
  - word access with addr[1:0] != 0.
  - A fault issues no memory command; resp_valid_o=1, resp_fault_o=1 in the next cycle; state stays IDLE.
- States and transitions:
  - IDLE: accept -> ISSUE (or respond, if faulting).
  - ISSUE: mem_valid_o=1 for exactly one cycle, mem_addr_o=index.
    - Load or byte store: mem_r_not_w_o=1 -> CAPTURE.
    - Word store: mem_r_not_w_o=0, mem_data_o=wdata -> IDLE with response.
  - CAPTURE: samples mem_data_i. This must be exactly one cycle after the read strobe, because memory returns 0 otherwise.
    - Load -> IDLE with response.
    - Byte store -> WRITE.
  - WRITE: mem_valid_o=1, mem_r_not_w_o=0, mem_data_o = captured word with byte lane addr[1:0] replaced by wdata[7:0] (lane 0 = bits 7:0, little-endian) -> IDLE with response.
- Response signals:
  - resp_valid_o is a single-cycle pulse in the first IDLE cycle after completion.
  - resp_we_o=1 only for non-faulting loads.
  - Word load data = captured word; byte load data = selected lane, zero-extended.
- Latency, accept edge to resp_valid_o high:
  - fault 1 cycle
  - word store 2 cycles
  - word or byte load 3 cycles
  - byte store 4 cycles
- Back-to-back requests:
  - A new request may be accepted in the same cycle resp_valid_o is high.
  - At most one request is in flight.
  - No backpressure on response; writeback must take the pulse.
- mem_valid_o is 0 in every state other than ISSUE and WRITE. mem_addr_o and mem_data_o hold their last values when idle.

Optional Feature:
- Macro MAU_BYTE_ACCESS_EN.
- Defined: byte loads/stores behave as above, including read-modify-write for byte stores.
- Undefined: no byte path is generated and state WRITE does not exist. Any request with req_byte_i=1 faults at accept: fault response next cycle, no memory command.

Test Plan:
- Word store addr 0x8, data 0xDEADBEEF, then word load addr 0x8, rd 3:
  - store: mem write to index 2, response 2 cycles after accept;
  - load: resp_data_o=0xDEADBEEF, resp_we_o=1, resp_rd_o=3, 3 cycles after accept.
- Byte store 0xAB to addr 0x5 over memory word 0x11223344 at index 1 (MAU_BYTE_ACCESS_EN):
  - read then write of index 1 with 0x1122AB44;
  - byte load addr 0x5 returns 0x000000AB.
- Word load addr 0x6 -> resp_fault_o=1, resp_we_o=0, resp_data_o=0 next cycle, mem_valid_o never asserted.
- Word load addr 0x30 (index 12, DEPTH=12) -> fault next cycle, no memory command.
- Two loads held back-to-back on req_valid_i -> second accepted in the cycle the first's resp_valid_o is high; exactly one mem_valid_o per load.
- reset_ni pulsed low during CAPTURE of a load:
  - outputs go to 0 immediately;
  - no resp_valid_o follows;
  - req_ready_o=1 the cycle after release.
